// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operand width,
// operation and state encodings, and a magnitude helper.
package mdu_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mdu_state_e;

  // Two's-complement magnitude; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration of the multiply/divide datapath: shift-add for
// multiply, restoring shift-subtract for divide.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic               q_bit
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;

  always_comb begin
    acc_nxt = '0;
    q_bit   = 1'b0;
    addend  = acc[0] ? {1'b0, operand} : '0;
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + addend;
    part    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = part - {1'b0, operand};
    if (is_div) begin
      // Remainder stays below the divisor, so a non-borrow result fits WIDTH bits.
      // The LSB is left clear; the caller merges in q_bit.
      q_bit   = ~diff[WIDTH];
      acc_nxt = {(q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO result registers.
//   state  | meaning
//   S_IDLE | waiting for start; hi/lo hold the last result
//   S_CALC | 32 radix-2 steps on magnitudes, one per cycle
//   S_FIX  | sign correction, hi/lo written
//   S_DONE | one-cycle done pulse, start still ignored
module mdu_iter #(
  parameter int WIDTH = mdu_pkg::WIDTH,
  parameter int CNT_W = mdu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import mdu_pkg::*;

  mdu_state_e         state_q, state_d;
  logic               is_div_q;
  logic               psign_q;
  logic               rsign_q;
  logic               dz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [2*WIDTH-1:0] step_acc;
  logic               step_q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               accept;
  logic               b_zero;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .operand (opnd_q),
    .acc_nxt (step_acc),
    .q_bit   (step_q_bit)
  );

  assign accept = (state_q == S_IDLE) && start;
  assign b_zero = (b == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = (op[1] && b_zero) ? S_DONE : S_CALC;
      S_CALC: if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prod_fix = psign_q ? (~acc_q + 1'b1) : acc_q;
    quo_fix  = psign_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = rsign_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      psign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_div_q <= op[1];
        psign_q  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        rsign_q  <= op[0] & a[WIDTH-1];
        dz_q     <= op[1] & b_zero;
        cnt_q    <= '0;
        acc_q    <= {{WIDTH{1'b0}}, mag(a, op[0])};
        opnd_q   <= mag(b, op[0]);
      end
      if (state_q == S_CALC) begin
        acc_q <= is_div_q ? {step_acc[2*WIDTH-1:1], step_q_bit} : step_acc;
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q == S_FIX) begin
        hi_q <= is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        lo_q <= is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a vector table of operations with hand-computed
// results, plus sequences for busy-ignored starts and mid-operation reset.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_iter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Issue one op; extra>0 drives a competing start in that observed cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input int extra, output int lat, output int ndone, output int nbusy);
    @(negedge clk);
    op = o; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0; ndone = 0; nbusy = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = n;
      end
      if (n == extra) begin
        start = 1'b1; op = MDU_MULTU; a = 32'd3; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (!busy) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, ndone, nbusy, cnt_done;

    vecs[0]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34};
    vecs[1]  = '{MDU_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
    vecs[2]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
    vecs[3]  = '{MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 34};
    vecs[4]  = '{MDU_DIV,   32'd5,        32'd0,        32'd2,        32'd14,       1'b1, 1};
    vecs[5]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
    vecs[6]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
    vecs[7]  = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 34};
    vecs[8]  = '{MDU_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 34};
    vecs[9]  = '{MDU_DIVU,  32'd0,        32'd0,        32'h00000001, 32'h23456780, 1'b1, 1};
    vecs[10] = '{MDU_DIVU,  32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0, 34};
    vecs[11] = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
    vecs[12] = '{MDU_DIV,   32'h80000000, 32'd3,        32'hFFFFFFFE, 32'hD5555556, 1'b0, 34};
    vecs[13] = '{MDU_DIVU,  32'h80000000, 32'd3,        32'h00000002, 32'h2AAAAAAA, 1'b0, 34};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, ndone, nbusy);
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_ndone", i), 64'(ndone), 64'd1);
      check($sformatf("v%0d_nbusy", i), 64'(nbusy), 64'(vecs[i].lat));
      check($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      check($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
    end

    repeat (5) @(negedge clk);
    check("hold_hilo", {hi, lo}, {32'h00000002, 32'h2AAAAAAA});

    // Competing start early in CALC, then during the DONE cycle.
    run_op(MDU_MULTU, 32'h00010000, 32'h00010000, 4, lat, ndone, nbusy);
    check("ign4_lat", 64'(lat), 64'd34);
    check("ign4_ndone", 64'(ndone), 64'd1);
    check("ign4_nbusy", 64'(nbusy), 64'd34);
    check("ign4_hilo", {hi, lo}, {32'h00000001, 32'h00000000});
    run_op(MDU_MULT, 32'hFFFFFFFE, 32'd5, 34, lat, ndone, nbusy);
    check("ign34_ndone", 64'(ndone), 64'd1);
    check("ign34_nbusy", 64'(nbusy), 64'd34);
    check("ign34_hilo", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFF6});
    @(negedge clk);
    check("ign34_idle", 64'(busy), 64'd0);

    // Reset in the middle of CALC.
    @(negedge clk);
    op = MDU_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hilo", {hi, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) cnt_done++;
    end
    check("mid_rst_no_done", 64'(cnt_done), 64'd0);
    run_op(MDU_DIVU, 32'd100, 32'd7, 0, lat, ndone, nbusy);
    check("post_rst_lat", 64'(lat), 64'd34);
    check("post_rst_hilo", {hi, lo}, {32'd2, 32'd14});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
